// File: rtl/rv32i_types.sv
// Shared types for the completion path: the result entry carried on the
// common data bus and the functional-unit index constants.
package rv32i_types;

  localparam int unsigned ROB_IDX_W = 5;
  localparam int unsigned DATA_W    = 32;

  // Requester indices on the CDB arbiter.
  localparam int unsigned FU_ALU = 0;
  localparam int unsigned FU_MUL = 1;
  localparam int unsigned FU_LSU = 2;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [4:0]           rd_addr;
    logic [DATA_W-1:0]    data;
    logic                 regf_we;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Single-clock result FIFO holding cdb_entry_t records for one functional unit.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          synchronous clear of all entries (overrides push/pop)
//   push, wdata    enqueue request and entry (caller guarantees !full)
//   pop            dequeue the head (caller guarantees !empty)
//   head           current head entry
//   count          number of stored entries (0..DEPTH)
//   full, empty    occupancy flags
module cdb_result_fifo
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  cdb_entry_t               wdata,
  output cdb_entry_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  cdb_entry_t           mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [$clog2(DEPTH):0] count_q, count_d;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty = (count_q == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= ($clog2(DEPTH)+1)'(DEPTH));
  a_push_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> !full);
  a_pop_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> !empty);

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each functional unit queues completed results in
// its own FIFO; a round-robin arbiter broadcasts one result per cycle on a
// registered CDB, stalled by cdb_ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous squash of queued and pending results
//   fu_valid/fu_ready     per-unit offer / FIFO-can-accept
//   fu_rob_idx, fu_rd_addr, fu_data, fu_regf_we
//                         per-unit result fields, packed unit 0 in the LSBs
//   cdb_ready             consumers accept the current broadcast
//   cdb_valid, cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we, cdb_src
//                         registered broadcast and the winning unit index
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NUM_FU        = 3,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned ROB_IDX_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [NUM_FU-1:0]                 fu_valid,
  output logic [NUM_FU-1:0]                 fu_ready,
  input  logic [NUM_FU*ROB_IDX_WIDTH-1:0]   fu_rob_idx,
  input  logic [NUM_FU*5-1:0]               fu_rd_addr,
  input  logic [NUM_FU*DATA_WIDTH-1:0]      fu_data,
  input  logic [NUM_FU-1:0]                 fu_regf_we,
  input  logic                              cdb_ready,
  output logic                              cdb_valid,
  output logic [ROB_IDX_WIDTH-1:0]          cdb_rob_idx,
  output logic [4:0]                        cdb_rd_addr,
  output logic [DATA_WIDTH-1:0]             cdb_data,
  output logic                              cdb_regf_we,
  output logic [$clog2(NUM_FU)-1:0]         cdb_src
);

  localparam int unsigned SRC_W = $clog2(NUM_FU);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  cdb_entry_t             in_entry   [NUM_FU];
  cdb_entry_t             head_entry [NUM_FU];
  logic [CNT_W-1:0]       fifo_count [NUM_FU];
  logic [NUM_FU-1:0]      fifo_full;
  logic [NUM_FU-1:0]      fifo_empty;
  logic [NUM_FU-1:0]      push;
  logic [NUM_FU-1:0]      pop;

  logic                   cdb_valid_q;
  cdb_entry_t             cdb_q;
  logic [SRC_W-1:0]       src_q;
  logic [SRC_W-1:0]       rr_ptr_q;

  logic                   load_en;
  logic                   found;
  logic [SRC_W-1:0]       winner;
  cdb_entry_t             win_entry;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign in_entry[g] = '{
      rob_idx: fu_rob_idx[g*ROB_IDX_WIDTH +: ROB_IDX_WIDTH],
      rd_addr: fu_rd_addr[g*5 +: 5],
      data:    fu_data[g*DATA_WIDTH +: DATA_WIDTH],
      regf_we: fu_regf_we[g]
    };
    assign fu_ready[g] = (fifo_count[g] < CNT_W'(FIFO_DEPTH));
    assign push[g]     = fu_valid[g] && fu_ready[g];

    cdb_result_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata (in_entry[g]),
      .head  (head_entry[g]),
      .count (fifo_count[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  assign load_en = !cdb_valid_q || cdb_ready;

  // First non-empty FIFO scanning upward from rr_ptr, wrapping at NUM_FU.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (!found && !fifo_empty[(32'(rr_ptr_q) + k) % NUM_FU]) begin
        found  = 1'b1;
        winner = SRC_W'((32'(rr_ptr_q) + k) % NUM_FU);
      end
    end
  end

  always_comb begin
    win_entry = head_entry[winner];
    win_entry.regf_we = head_entry[winner].regf_we &&
                        (head_entry[winner].rd_addr != 5'd0);
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      pop[i] = load_en && found && !flush && (32'(winner) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
      src_q       <= '0;
      rr_ptr_q    <= '0;
    end else if (flush) begin
      cdb_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else if (load_en) begin
      if (found) begin
        cdb_valid_q <= 1'b1;
        cdb_q       <= win_entry;
        src_q       <= winner;
        rr_ptr_q    <= (32'(winner) == NUM_FU - 1) ? '0 : winner + 1'b1;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_idx = cdb_q.rob_idx;
  assign cdb_rd_addr = cdb_q.rd_addr;
  assign cdb_data    = cdb_q.data;
  assign cdb_regf_we = cdb_q.regf_we;
  assign cdb_src     = src_q;

  a_cdb_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (cdb_valid_q && !cdb_ready && !flush) |=>
      (cdb_valid_q && $stable(cdb_q) && $stable(src_q)));
  a_ready_is_full_n: assert property (@(posedge clk) disable iff (!rst_n)
    fu_ready == ~fifo_full);

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single common data bus between the functional units (integer ALU, multiplier, load/store) that complete out of order. Each unit pushes completed results into a small per-unit result FIFO. A round-robin arbiter broadcasts at most one result per cycle on a registered CDB, with ROB backpressure. It sits between the execute units and the reservation stations, register file and ROB, which all snoop the CDB.

Parameters:
NUM_FU, 3, number of requesting functional units (index 0 = ALU, 1 = MUL, 2 = LSU)
FIFO_DEPTH, 2, entries per result FIFO; must be a power of two and at least 2
ROB_IDX_WIDTH, 5, ROB index width
DATA_WIDTH, 32, result data width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous squash of all queued and pending results
fu_valid  in  NUM_FU  unit i offers a result
fu_ready  out  NUM_FU  unit i's FIFO can accept
fu_rob_idx  in  NUM_FU x ROB_IDX_WIDTH  ROB index of the offered result
fu_rd_addr  in  NUM_FU x 5  destination architectural register
fu_data  in  NUM_FU x DATA_WIDTH  result value
fu_regf_we  in  NUM_FU  result writes the register file
cdb_ready  in  1  ROB/consumers accept the current broadcast
cdb_valid  out  1  broadcast valid
cdb_rob_idx  out  ROB_IDX_WIDTH  broadcast ROB index
cdb_rd_addr  out  5  broadcast destination register
cdb_data  out  DATA_WIDTH  broadcast value
cdb_regf_we  out  1  broadcast register write enable
cdb_src  out  $clog2(NUM_FU)  index of the unit that won the broadcast

Behaviour:
- Reset (rst_n low, asynchronous): all FIFO counts and pointers = 0; rr_ptr = 0; cdb_valid = 0; cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we and cdb_src = 0. fu_ready reads all 1s once reset is released. Reset mid-operation drops all results with no broadcast.
- fu_ready[i] = (count[i] < FIFO_DEPTH). It depends only on registered state, never on fu_valid or cdb_ready.
- Enqueue: a result is pushed on the edge where fu_valid[i] && fu_ready[i]. Wrap-around: pointers increment modulo FIFO_DEPTH. fu_valid while not ready is ignored; the unit must hold the result.
- Output register load condition: load_en = !cdb_valid || cdb_ready. If cdb_valid && !cdb_ready, all cdb_* outputs hold and no FIFO is popped.
- Arbitration, when load_en:
  - Scan FIFOs rr_ptr, rr_ptr+1, ... (mod NUM_FU); the first non-empty FIFO wins.
  - Pop its head into the output register and set cdb_valid = 1, cdb_src = winner.
  - Update rr_ptr = (winner+1) mod NUM_FU.
  - If every FIFO is empty: cdb_valid = 0, rr_ptr unchanged, data fields hold their previous values.
- No bypass: an entry pushed at edge E is visible to the arbiter from edge E+1, so the earliest broadcast is on the cdb_* outputs after edge E+1.
- Simultaneous push and pop on the same FIFO in one edge: count is unchanged and both take effect. A full FIFO being popped still shows fu_ready=0 that cycle.
- cdb_regf_we = entry.regf_we && (entry.rd_addr != 0).
- Throughput: 1 broadcast per cycle while cdb_ready=1. Fairness: with all FIFOs non-empty, each unit wins once every NUM_FU cycles.
- flush: on the next edge all counts = 0, cdb_valid = 0, rr_ptr = 0. It overrides any same-cycle enqueue and load, and takes effect even if cdb_valid && !cdb_ready.
- Assertions: fu_ready must be 1 whenever a push occurs; count stays at or below FIFO_DEPTH; cdb_* must be stable while cdb_valid && !cdb_ready.

Decomposition:
- Shared package rv32i_types holds:
  - cdb_entry_t struct: rob_idx[4:0], rd_addr[4:0], data[31:0], regf_we.
  - Constants FU_ALU=0, FU_MUL=1, FU_LSU=2.
- One sub-module, cdb_result_fifo: a single-clock FIFO of cdb_entry_t with ports push, pop, head, count, full, empty, flush. It uses the same async active-low reset. cdb_arbiter instantiates NUM_FU copies.

Test Plan:
- Single result: after reset, unit 1 pushes rob_idx=3, rd=x5, data=0x1234, we=1, cdb_ready=1 → cdb_valid=1 two edges later with rob_idx=3, rd_addr=5, data=0x1234, regf_we=1, cdb_src=1; then cdb_valid=0.
- Round-robin: all three units push one result in the same cycle, rr_ptr=0, cdb_ready=1 → broadcasts on 3 consecutive cycles in order src 0,1,2; a second round with rr_ptr=1 gives 1,2,0.
- Backpressure: unit 0 pushes 3 results with cdb_ready=0 → the first sits on the CDB held stable and the other two fill the FIFO; fu_ready[0]=0 and a 4th fu_valid is not accepted. After cdb_ready=1 the three results come out in push order.
- x0 suppression: push with rd_addr=0, regf_we=1, data=0xDEAD → broadcast has cdb_regf_we=0, data=0xDEAD.
- Flush: fill FIFOs with 2 entries each and hold cdb_valid=1 with cdb_ready=0; assert flush for one cycle with fu_valid[2]=1 → next cycle cdb_valid=0, fu_ready=3'b111, and the unit 2 result is dropped.
- Async reset: pull rst_n low between clock edges while cdb_valid=1 → cdb_valid=0 immediately without waiting for an edge; no broadcast follows rst_n release.
